// File: rtl/morse_pkg.sv
// Shared Morse digit definitions.
// Holds the sequencer state encoding, the element timing constants and the digit pattern table.
package morse_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t LOAD     = 3'd1;
  localparam state_t ELEM_ON  = 3'd2;
  localparam state_t ELEM_GAP = 3'd3;
  localparam state_t CHAR_GAP = 3'd4;

  localparam int ELEMS_PER_DIGIT = 5;
  localparam int DOT_UNITS       = 1;
  localparam int DASH_UNITS      = 3;
  localparam int ELEM_GAP_UNITS  = 1;
  localparam int CHAR_GAP_UNITS  = 3;

  // Bit i is element i (bit 0 is sent first); 1 = dash. Listed from digit 9 down to digit 0.
  localparam logic [9:0][4:0] DIGIT_PATTERNS = {
    5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000,
    5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111
  };

  function automatic logic [4:0] digit_pattern(input logic [3:0] d);
    return (d > 4'd9) ? 5'b00000 : DIGIT_PATTERNS[d];
  endfunction

endpackage

// File: rtl/morse_digit_fifo.sv
// Small synchronous FIFO holding queued digit codes.
// DEPTH must be a power of two so the pointers wrap naturally.
module morse_digit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/morse_msg_ctrl.sv
// Morse digit message controller: queues digit codes and keys them out as timed dots and dashes.
// Every state's duration is counted in whole units of UNIT_DIV clock cycles.
module morse_msg_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [3:0] wr_digit,
  output logic       wr_ready,
  output logic       mors,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [23:0] UNIT_LAST = 24'(UNIT_DIV - 1);

  state_t      state;
  state_t      next;
  logic [23:0] cyc;
  logic [1:0]  units;
  logic [1:0]  units_last;
  logic [2:0]  idx;
  logic [4:0]  pat;
  logic [3:0]  head;
  logic        full;
  logic        empty;
  logic        pop;
  logic        accept;
  logic        push;
  logic        unit_end;
  logic        state_end;

  assign wr_ready  = !full && !rst;
  assign accept    = wr_valid && wr_ready;
  assign push      = accept && (wr_digit <= 4'd9);
  assign busy      = (state != IDLE);
  assign unit_end  = (cyc == UNIT_LAST);
  assign state_end = unit_end && (units == units_last);

  morse_digit_fifo #(.DEPTH(4), .WIDTH(4)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_digit),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    units_last = 2'(CHAR_GAP_UNITS - 1);
    case (state)
      ELEM_ON:  units_last = pat[idx] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
      ELEM_GAP: units_last = 2'(ELEM_GAP_UNITS - 1);
      default:  ;
    endcase
  end

  always_comb begin
    next = state;
    pop  = 1'b0;
    case (state)
      IDLE:     if (!empty) next = LOAD;
      LOAD: begin
        pop  = 1'b1;
        next = ELEM_ON;
      end
      ELEM_ON:  if (state_end) next = (idx < 3'(ELEMS_PER_DIGIT - 1)) ? ELEM_GAP : CHAR_GAP;
      ELEM_GAP: if (state_end) next = ELEM_ON;
      CHAR_GAP: if (state_end) next = empty ? IDLE : LOAD;
      default:  next = IDLE;
    endcase
  end

  // mors is driven from the next state so it is high exactly during ELEM_ON cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
      units <= '0;
      idx   <= '0;
      mors  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next;
      mors  <= (next == ELEM_ON);
      done  <= (state == CHAR_GAP) && (next == IDLE);
      err   <= accept && (wr_digit > 4'd9);
      if (next != state || state == IDLE || state == LOAD) begin
        cyc   <= '0;
        units <= '0;
      end else if (unit_end) begin
        cyc   <= '0;
        units <= units + 1'b1;
      end else begin
        cyc <= cyc + 1'b1;
      end
      if (state == LOAD) idx <= '0;
      else if (state == ELEM_GAP && state_end) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) pat <= digit_pattern(head);
  end

endmodule

// File: doc/morse_msg_ctrl.md
MORSE_MSG_CTRL -- requirements
Module: morse_msg_ctrl

Interface
REQ-001 Parameter UNIT_DIV, default 12_500_000, meaning clk cycles per Morse unit; legal range 1 to 2^24-1.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_valid  input  1  digit offered on wr_digit this cycle.
REQ-005 wr_digit  input  4  digit code; 0-9 are legal, 10-15 are illegal.
REQ-006 wr_ready  output  1  buffer can accept a digit; a transfer occurs when wr_valid and wr_ready are both high.
REQ-007 mors  output  1  registered keyed Morse output; 1 means tone on.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the sequencer returns to IDLE.
REQ-010 err  output  1  one-cycle pulse for each accepted illegal digit.

Function
REQ-011 The block SHALL buffer digits in a 4-entry FIFO; wr_ready SHALL equal not-full.
REQ-012 Simultaneous push and pop with the FIFO not full SHALL both take effect, with the count unchanged.
REQ-013 A push while full SHALL never occur, because wr_ready is low.
REQ-014 An accepted illegal digit SHALL NOT be stored, and err SHALL pulse on the following cycle.
REQ-015 Digit patterns SHALL be the standard 5-element Morse digits:
- 1 = .----, 2 = ..---, 3 = ...--, 4 = ....-, 5 = .....
- 6 = -...., 7 = --..., 8 = ---.., 9 = ----., 0 = -----
REQ-016 The FSM states SHALL be IDLE, LOAD, ELEM_ON, ELEM_GAP and CHAR_GAP.
REQ-017 IDLE -> LOAD when the FIFO is non-empty.
- LOAD SHALL last 1 cycle.
- LOAD SHALL pop the head digit and latch its 5-element pattern.
- LOAD SHALL clear the element index.
REQ-018 ELEM_ON SHALL hold mors=1 for 1 unit (dot) or 3 units (dash), 1 unit being UNIT_DIV cycles.
REQ-019 After ELEM_ON:
- ELEM_GAP (mors=0, 1 unit) if the element index is below 4, then ELEM_ON with the index incremented.
- Otherwise CHAR_GAP (mors=0, 3 units).
REQ-020 CHAR_GAP ends in LOAD if the FIFO is non-empty, otherwise in IDLE with done pulsed in the first IDLE cycle.
REQ-021 The unit cycle counter and unit counter SHALL clear on every state entry, so every state duration is exact.
REQ-022 mors SHALL be registered so that it is high exactly during ELEM_ON cycles, with no glitch at state edges.
REQ-023 Total cycles per digit from LOAD entry to CHAR_GAP exit SHALL be 1 + (D + 7) * UNIT_DIV, where D is the sum of element on-units.
- Digit 5: 1 + 12*UNIT_DIV.
- Digit 0: 1 + 22*UNIT_DIV.
REQ-024 Pushes SHALL be accepted in every state, including mid-character.

Reset
REQ-025 On rst the block SHALL clear the state to IDLE, flush the FIFO and zero all counters, taking effect on the next clock edge.
REQ-026 Output values during reset:
- mors=0, busy=0, done=0, err=0.
- wr_ready=0 while rst is high.
- wr_ready=1 on the first cycle after rst deasserts.
REQ-027 A reset asserted mid-element SHALL drop mors on the next edge, and no pending digit SHALL be emitted afterwards.

Structure
REQ-028 A shared package morse_pkg SHALL hold:
- the state enumeration;
- the 10-entry digit pattern constant table (5 bits each, 1 = dash);
- the constants ELEMS_PER_DIGIT=5, DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3.
REQ-029 The FIFO SHALL be one sub-module, morse_digit_fifo (parameter depth 4, width 4); the FSM and unit timing SHALL remain in morse_msg_ctrl.

Verification (UNIT_DIV=2)
REQ-030 Reset, then push digit 5 -> mors shows 5 high pulses of 2 cycles separated by 2-cycle lows; busy is high for 25 cycles; done pulses once.
REQ-031 Push digit 0 -> mors shows 5 high pulses of 6 cycles each, and LOAD-to-IDLE spans 45 cycles.
REQ-032 Push 1,2,3,4,9 back-to-back:
- wr_ready drops after 4 digits are stored.
- The 5th digit is accepted after the first pop.
- All 5 digits are emitted in order with 6-cycle gaps between characters.
- done pulses only after the last digit.
REQ-033 Push digit 12 -> err pulses 1 cycle later, mors stays 0 and busy stays 0.
REQ-034 Assert rst during the third element of digit 7 with 2 digits queued -> mors=0 the next cycle, and no further output occurs after rst deasserts.
REQ-035 Push digit 8 while digit 6 is in CHAR_GAP -> the transition is CHAR_GAP -> LOAD with no IDLE cycle, and done does not pulse between the two digits.
